mips_rf_write_arbiter: RTL and testbench
========================================

MIPS_RF_WRITE_ARBITER -- requirements
Module: mips_rf_write_arbiter

Interface
REQ-001 SHALL have parameter LINK_OFFSET, default 2, the value added to jal_pc to form the link address.
REQ-002 SHALL have parameter LINK_REG, default 31, the destination register of every link write.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports alu_valid (in, 1), alu_reg (in, 5), alu_data (in, 32), alu_ready (out, 1): the ALU writeback requester.
REQ-006 SHALL have ports mem_valid (in, 1), mem_reg (in, 5), mem_data (in, 32), mem_ready (out, 1): the load writeback requester.
REQ-007 SHALL have ports jal_valid (in, 1), jal_pc (in, 32), jal_ready (out, 1): the link-write requester.
REQ-008 SHALL have port rf_hold, input, 1 bit: when high, no grant is issued.
REQ-009 SHALL have ports rf_write_en (out, 1), rf_write_reg (out, 5), rf_write_data (out, 32): the registered register-file write port.
REQ-010 SHALL have port grant_id, output, 2 bits: the requester granted last cycle (0 ALU, 1 MEM, 2 JAL, 3 none).
REQ-011 SHALL have port pending_mask, output, 32 bits: bit r is set while any valid, ungranted request targets register r.

Function
REQ-012 SHALL complete a handshake when valid and ready are both high in the same cycle; ready is combinational from the valid inputs, rr_ptr and rf_hold.
REQ-013 SHALL assert at most one ready per cycle, and none while rf_hold is high.
REQ-014 SHALL arbitrate round-robin with a 2-bit rr_ptr in {0,1,2}; the search order starts at rr_ptr and proceeds upward mod 3.
REQ-015 SHALL set rr_ptr to (granted id + 1) mod 3 after a grant, and SHALL leave it unchanged when no grant occurs.
REQ-016 SHALL register the granted write: one cycle after the handshake, rf_write_reg and rf_write_data hold the granted destination and data (fixed latency 1).
REQ-017 SHALL form the JAL write as register LINK_REG with data jal_pc + LINK_OFFSET, modulo 2^32.
REQ-018 SHALL accept a grant whose destination is register 0, but SHALL hold rf_write_en low for that write.
REQ-019 SHALL hold rf_write_en low and grant_id at 3 in any cycle that follows a cycle with no grant.
REQ-020 SHALL require each requester to hold valid, reg and data stable while valid is high and ready is low; a violation is a requester error and causes no arbiter recovery action.
REQ-021 SHALL serialise same-destination requests in grant order, so the later grant is the surviving write.
REQ-022 SHALL grant all three requesters within three consecutive unheld cycles when all three are valid.
REQ-023 SHALL compute pending_mask combinationally, excluding a request in the cycle it is granted, and SHALL never set bit 0.

Reset
REQ-024 SHALL, on reset, drive rf_write_en to 0, rf_write_reg to 0, rf_write_data to 0, grant_id to 3 and rr_ptr to 0.
REQ-025 SHALL assert no ready during a reset cycle; any write registered in the cycle before reset is discarded.
REQ-026 SHALL release from reset with ALU at highest priority on the first cycle.

Structure
REQ-027 SHALL take the requester IDs (ALU=0, MEM=1, JAL=2, NONE=3), the 5-bit register index type and LINK_REG from the shared package mips_pkg.
REQ-028 SHALL place the round-robin pointer and grant logic in one sub-module, rr_arbiter3; the datapath mux and output registers stay in the top module.

Verification
REQ-029 Scenario: after reset, alu_valid with reg=5, data=0x1234 -> alu_ready high the same cycle; next cycle rf_write_en=1, reg=5, data=0x1234, grant_id=0.
REQ-030 Scenario: all three valid from rr_ptr=0 (alu reg 3, mem reg 4, jal_pc=0x100) -> grants ALU, MEM, JAL on consecutive cycles; third write is reg 31, data 0x102.
REQ-031 Scenario: mem_valid with reg=0, data=0xFFFF -> mem_ready=1; next cycle rf_write_en=0, grant_id=1.
REQ-032 Scenario: rf_hold=1 for 3 cycles with alu reg 7 valid -> no ready; pending_mask=0x80 throughout; grant on the first cycle after hold drops.
REQ-033 Scenario: ALU and MEM both target reg 9 (data 0xA, 0xB), rr_ptr=1 -> MEM granted first, then ALU; the final write is 0xA.
REQ-034 Scenario: reset asserted the cycle after a grant -> rf_write_en=0, grant_id=3; the next arbitration starts at ALU.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register-file write path.
//   req_id_t  : requester identifier (ALU=0, MEM=1, JAL=2, NONE=3)
//   reg_idx_t : 5-bit architectural register index
//   LINK_REG  : destination register of every link (jal) write
//   next_id   : round-robin successor within {ALU, MEM, JAL}
package mips_pkg;

    typedef logic [4:0] reg_idx_t;
    typedef logic [1:0] req_id_t;

    localparam req_id_t  ID_ALU   = 2'd0;
    localparam req_id_t  ID_MEM   = 2'd1;
    localparam req_id_t  ID_JAL   = 2'd2;
    localparam req_id_t  ID_NONE  = 2'd3;

    localparam reg_idx_t LINK_REG = 5'd31;

    // Successor modulo 3; NONE never reaches here in practice.
    function automatic req_id_t next_id(input req_id_t id);
        return (id == ID_JAL) ? ID_ALU : req_id_t'(id + 2'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter for the register-file write port.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_req[2:0]     : request vector indexed by requester id
//   i_hold         : suppresses every grant while high
//   o_gnt[2:0]     : one-hot grant (combinational)
//   o_gnt_id       : id of the granted requester, NONE when idle
module rr_arbiter3 (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_req,
    input  logic       i_hold,
    output logic [2:0] o_gnt,
    output logic [1:0] o_gnt_id
);
    import mips_pkg::*;

    logic [1:0] r_ptr;     // highest-priority requester this cycle
    logic [1:0] w_idx;
    logic [3:0] w_req;     // padded so a 2-bit index is always in range

    assign w_req = {1'b0, i_req};

    // Walk ptr, ptr+1, ptr+2 (mod 3); first active request wins.
    // No grant is issued during reset so nothing handshakes then.
    always_comb begin
        o_gnt_id = ID_NONE;
        w_idx    = r_ptr;
        if (!i_reset && !i_hold) begin
            for (int k = 0; k < 3; k++) begin
                if (o_gnt_id == ID_NONE && w_req[w_idx])
                    o_gnt_id = w_idx;
                w_idx = next_id(w_idx);
            end
        end
    end

    always_comb begin
        o_gnt    = '0;
        o_gnt[0] = (o_gnt_id == ID_ALU);
        o_gnt[1] = (o_gnt_id == ID_MEM);
        o_gnt[2] = (o_gnt_id == ID_JAL);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_ptr <= ID_ALU;
        else if (o_gnt_id != ID_NONE)
            r_ptr <= next_id(o_gnt_id);
    end

endmodule

// File: rtl/mips_rf_write_arbiter.sv
// Register-file write arbiter: ALU, load and link (jal) writebacks compete
// for the single register-file write port.
//   clk, reset                 : clock, synchronous active-high reset
//   alu_* / mem_*              : valid/reg/data requesters with ready
//   jal_valid/jal_pc/jal_ready : link write to LINK_REG of jal_pc+LINK_OFFSET
//   rf_hold                    : blocks all grants
//   rf_write_en/reg/data       : registered write port (latency 1)
//   grant_id                   : requester granted last cycle (3 = none)
//   pending_mask               : destinations of valid, not-yet-granted requests
module mips_rf_write_arbiter #(
    parameter int unsigned LINK_OFFSET = 2,
    parameter logic [4:0]  LINK_REG    = mips_pkg::LINK_REG
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        jal_valid,
    input  logic [31:0] jal_pc,
    output logic        jal_ready,
    input  logic        rf_hold,
    output logic        rf_write_en,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data,
    output logic [1:0]  grant_id,
    output logic [31:0] pending_mask
);
    import mips_pkg::*;

    logic [2:0]  w_gnt;
    logic [1:0]  w_gnt_id;
    reg_idx_t    w_dst;
    logic [31:0] w_dat;
    logic [31:0] w_link_data;

    logic        r_we;
    reg_idx_t    r_reg;
    logic [31:0] r_data;
    logic [1:0]  r_gid;

    rr_arbiter3 u_arb (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_req    ({jal_valid, mem_valid, alu_valid}),
        .i_hold   (rf_hold),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    assign alu_ready = w_gnt[0];
    assign mem_ready = w_gnt[1];
    assign jal_ready = w_gnt[2];

    // Link address wraps modulo 2^32.
    assign w_link_data = jal_pc + 32'(LINK_OFFSET);

    always_comb begin
        w_dst = '0;
        w_dat = '0;
        case (w_gnt_id)
            ID_ALU:  begin w_dst = alu_reg;  w_dat = alu_data;    end
            ID_MEM:  begin w_dst = mem_reg;  w_dat = mem_data;    end
            ID_JAL:  begin w_dst = LINK_REG; w_dat = w_link_data; end
            default: ;
        endcase
    end

    // A grant to r0 still completes the handshake but never writes.
    // Idle cycles leave reg/data as they were; only en and id drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_reg  <= '0;
            r_data <= '0;
            r_gid  <= ID_NONE;
        end else if (w_gnt_id != ID_NONE) begin
            r_we   <= (w_dst != 5'd0);
            r_reg  <= w_dst;
            r_data <= w_dat;
            r_gid  <= w_gnt_id;
        end else begin
            r_we   <= 1'b0;
            r_gid  <= ID_NONE;
        end
    end

    assign rf_write_en   = r_we;
    assign rf_write_reg  = r_reg;
    assign rf_write_data = r_data;
    assign grant_id      = r_gid;

    // The request being granted this cycle is no longer pending.
    always_comb begin
        pending_mask = '0;
        if (alu_valid && !w_gnt[0]) pending_mask[alu_reg]  = 1'b1;
        if (mem_valid && !w_gnt[1]) pending_mask[mem_reg]  = 1'b1;
        if (jal_valid && !w_gnt[2]) pending_mask[LINK_REG] = 1'b1;
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_mips_rf_write_arbiter.sv
module tb_mips_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0, jal_valid = 1'b0;
    logic [4:0]  alu_reg = '0, mem_reg = '0;
    logic [31:0] alu_data = '0, mem_data = '0, jal_pc = '0;
    logic        alu_ready, mem_ready, jal_ready;
    logic        rf_hold = 1'b0;
    logic        rf_write_en;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [1:0]  grant_id;
    logic [31:0] pending_mask;

    always #5 clk = ~clk;

    mips_rf_write_arbiter dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .jal_valid(jal_valid), .jal_pc(jal_pc), .jal_ready(jal_ready),
        .rf_hold(rf_hold),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .grant_id(grant_id), .pending_mask(pending_mask)
    );

    typedef struct {
        logic [1:0]  id;
        logic        en;
        logic [4:0]  rg;
        logic [31:0] dat;
        bit          full;   // reg/data are defined for this cycle
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Requester model: id 0 ALU, 1 MEM, 2 JAL (dt holds jal_pc).
    bit          v[3];
    logic [4:0]  rg[3];
    logic [31:0] dt[3];
    int          ptr = 0;       // id with top priority next cycle

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [4:0] dest(input int id);
        return (id == 2) ? 5'd31 : rg[id];
    endfunction

    function automatic logic [31:0] wdata(input int id);
        return (id == 2) ? dt[2] + 32'd2 : dt[id];
    endfunction

    // One cycle: drive at negedge, check combinational outputs, queue the
    // write expected on the following posedge, advance the model.
    task automatic step(input bit rst, input bit hold);
        exp_t e;
        int g;
        logic [31:0] pm;
        logic [2:0]  rdy;
        @(negedge clk);
        reset = rst; rf_hold = hold;
        alu_valid = v[0]; alu_reg = rg[0]; alu_data = dt[0];
        mem_valid = v[1]; mem_reg = rg[1]; mem_data = dt[1];
        jal_valid = v[2]; jal_pc  = dt[2];
        #2;
        g = 3;
        if (!rst && !hold)
            for (int k = 0; k < 3; k++)
                if (g == 3 && v[(ptr + k) % 3]) g = (ptr + k) % 3;
        rdy = '0;
        if (g != 3) rdy[g] = 1'b1;
        check("ready", {29'd0, jal_ready, mem_ready, alu_ready}, {29'd0, rdy});
        pm = '0;
        for (int i = 0; i < 3; i++)
            if (v[i] && i != g) pm[dest(i)] = 1'b1;
        pm[0] = 1'b0;
        check("pending_mask", pending_mask, pm);
        if (rst)
            e = '{id: 2'd3, en: 1'b0, rg: 5'd0, dat: 32'd0, full: 1'b1};
        else if (g != 3)
            e = '{id: 2'(g), en: (dest(g) != 5'd0), rg: dest(g), dat: wdata(g), full: 1'b1};
        else
            e = '{id: 2'd3, en: 1'b0, rg: 5'd0, dat: 32'd0, full: 1'b0};
        q.push_back(e);
        if (rst) ptr = 0;
        else if (g != 3) begin
            ptr = (g + 1) % 3;
            v[g] = 1'b0;
        end
    endtask

    task automatic req(input int id, input logic [4:0] r, input logic [31:0] d);
        v[id] = 1'b1; rg[id] = r; dt[id] = d;
    endtask

    // Monitor: the write port presents a result every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("grant_id", {30'd0, grant_id}, {30'd0, e.id});
                check("rf_write_en", {31'd0, rf_write_en}, {31'd0, e.en});
                if (e.full) begin
                    check("rf_write_reg", {27'd0, rf_write_reg}, {27'd0, e.rg});
                    check("rf_write_data", rf_write_data, e.dat);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin v[i] = 0; rg[i] = '0; dt[i] = '0; end
        // Reset, then a lone ALU write
        step(1, 0); step(1, 0);
        req(0, 5'd5, 32'h1234); step(0, 0);
        // All three from pointer 0
        step(1, 0);
        req(0, 5'd3, 32'hAAAA_0003); req(1, 5'd4, 32'hBBBB_0004); req(2, 5'd31, 32'h100);
        step(0, 0); step(0, 0); step(0, 0);
        // Load to r0: handshake without a write
        req(1, 5'd0, 32'hFFFF); step(0, 0); step(0, 0);
        // Held cycles
        req(0, 5'd7, 32'h77); step(0, 1); step(0, 1); step(0, 1); step(0, 0);
        // Same destination, MEM has priority
        step(1, 0); req(0, 5'd1, 32'h1); step(0, 0);
        req(0, 5'd9, 32'hA); req(1, 5'd9, 32'hB); step(0, 0); step(0, 0);
        // Reset right after a grant, then ALU first again
        req(1, 5'd2, 32'h22); step(0, 0);
        req(0, 5'd6, 32'h66); step(1, 0); step(0, 0); step(0, 0);
        // JAL link address wraps
        req(2, 5'd31, 32'hFFFF_FFFF); step(0, 0);
        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++)
                if (!v[i] && $urandom_range(0, 1) == 1)
                    req(i, ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 2)) : 5'($urandom),
                        $urandom);
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 4) == 0));
        end
        step(0, 0);
        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
